// File: rtl/program_sequencer.sv
// Program sequencer: IDLE/FETCH/DECODE/EXECUTE/HALT control with PC, instruction register and
// retired-instruction counter. Define SEQ_SINGLE_STEP_EN to add a Step input (one instruction per edge).
module program_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned INS_W = 15
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             Run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             Step,
`endif
  output logic             PM_Req,
  output logic [PC_W-1:0]  PM_Addr,
  input  logic             PM_Ack,
  input  logic [INS_W-1:0] PM_Data,
  output logic [INS_W-1:0] Ins,
  input  logic             Br_Take,
  input  logic [PC_W-1:0]  Br_Target,
  input  logic             Halt_Ins,
  output logic             Exec_En,
  output logic             Halted,
  output logic [15:0]      Ret_Cnt
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExecute, StHalt} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic [15:0]      ret_q, ret_d;
  logic             start;
  logic             again;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= Step;
    end
  end

  // Only a fresh Step edge releases an instruction; every instruction ends back in IDLE.
  assign start = Run & Step & ~step_q;
  assign again = 1'b0;
`else
  assign start = Run;
  assign again = Run;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ins_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    ret_d   = ret_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (PM_Ack) begin
          ins_d   = PM_Data;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        ret_d = ret_q + 16'd1;
        // HALT wins over a simultaneous branch and leaves the PC on the HALT instruction.
        if (Halt_Ins) begin
          state_d = StHalt;
        end else begin
          pc_d    = Br_Take ? Br_Target : pc_q + PC_W'(1);
          state_d = again ? StFetch : StIdle;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    PM_Req  = 1'b0;
    Exec_En = 1'b0;
    Halted  = 1'b0;
    case (state_q)
      StFetch:   PM_Req  = 1'b1;
      StExecute: Exec_En = 1'b1;
      StHalt:    Halted  = 1'b1;
      default:   ;
    endcase
  end

  assign PM_Addr = pc_q;
  assign Ins     = ins_q;
  assign Ret_Cnt = ret_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: instruction-level model compared every cycle plus
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_program_sequencer;
  localparam int PC_W  = 8;
  localparam int INS_W = 15;

  logic             clk = 1'b0;
  logic             nReset = 1'b0;
  logic             Run = 1'b0;
  logic             PM_Ack = 1'b0;
  logic             Br_Take = 1'b0;
  logic             Halt_Ins = 1'b0;
  logic [PC_W-1:0]  Br_Target = '0;
  logic [INS_W-1:0] PM_Data;
  logic             PM_Req, Exec_En, Halted;
  logic [PC_W-1:0]  PM_Addr;
  logic [INS_W-1:0] Ins;
  logic [15:0]      Ret_Cnt;
`ifdef SEQ_SINGLE_STEP_EN
  logic             Step = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  program_sequencer #(.PC_W(PC_W), .INS_W(INS_W)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .Run       (Run),
`ifdef SEQ_SINGLE_STEP_EN
    .Step      (Step),
`endif
    .PM_Req    (PM_Req),
    .PM_Addr   (PM_Addr),
    .PM_Ack    (PM_Ack),
    .PM_Data   (PM_Data),
    .Ins       (Ins),
    .Br_Take   (Br_Take),
    .Br_Target (Br_Target),
    .Halt_Ins  (Halt_Ins),
    .Exec_En   (Exec_En),
    .Halted    (Halted),
    .Ret_Cnt   (Ret_Cnt)
  );

  always #5 clk = ~clk;

  // Program memory contents: recognisable word tagged with its own address.
  function automatic logic [INS_W-1:0] mem(input logic [PC_W-1:0] a);
    return {7'h55, a};
  endfunction

  assign PM_Data = mem(PM_Addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: where the current instruction is (0 none, 1 fetching, 2 decoded, 3 executing, 4 halted)
  int               m_phase = 0;
  logic [PC_W-1:0]  m_pc = '0;
  logic [INS_W-1:0] m_ins = '0;
  logic [15:0]      m_ret = '0;
  logic             m_step_prev = 1'b0;

  task automatic model_step();
    int  nxt;
    logic start_ok, cont;
    if (!nReset) begin
      m_phase = 0; m_pc = '0; m_ins = '0; m_ret = '0; m_step_prev = 1'b0;
      return;
    end
`ifdef SEQ_SINGLE_STEP_EN
    start_ok = Run && Step && !m_step_prev;
    m_step_prev = Step;
    cont = 1'b0;
`else
    start_ok = Run;
    cont = Run;
`endif
    nxt = m_phase;
    if (m_phase == 0 && start_ok) nxt = 1;
    else if (m_phase == 1 && PM_Ack) begin
      m_ins = mem(m_pc);
      nxt = 2;
    end else if (m_phase == 2) nxt = 3;
    else if (m_phase == 3) begin
      m_ret = m_ret + 16'd1;
      if (Halt_Ins) nxt = 4;
      else begin
        m_pc = Br_Take ? Br_Target : m_pc + 8'd1;
        nxt = cont ? 1 : 0;
      end
    end
    m_phase = nxt;
  endtask

  initial forever begin
    @(posedge clk or negedge nReset);
    model_step();
  end

  logic prev_exec = 1'b0;
  initial forever begin
    @(negedge clk);
    chk("pm_req",  PM_Req,  m_phase == 1);
    chk("exec_en", Exec_En, m_phase == 3);
    chk("halted",  Halted,  m_phase == 4);
    chk("pm_addr", PM_Addr, m_pc);
    chk("ins",     Ins,     m_ins);
    chk("ret_cnt", Ret_Cnt, m_ret);
    chk("exec_gap", prev_exec & Exec_En, 0);
    prev_exec = Exec_En;
  end

  // Skip the rest of the current instruction and return the address of the next fetch.
  task automatic next_fetch(output logic [PC_W-1:0] a);
    int n;
    n = 0;
    while (PM_Req && n < 50) begin @(negedge clk); n++; end
    while (!PM_Req && n < 50) begin @(negedge clk); n++; end
    chk("fetch_timeout", n < 50, 1);
    a = PM_Addr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [PC_W-1:0] a;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_req", PM_Req, 0);
    chk("rst_ret", Ret_Cnt, 0);
    chk("rst_ins", Ins, 0);

`ifdef SEQ_SINGLE_STEP_EN
    Run = 1; PM_Ack = 1; nReset = 1; n = 0;
    for (int p = 0; p < 3; p++) begin
      Step = 1;
      repeat (8) begin @(negedge clk); if (Exec_En) n++; end
      if (p < 2) Step = 0;
      @(negedge clk); if (Exec_En) n++;
    end
    repeat (20) begin @(negedge clk); if (Exec_En) n++; end
    chk("step_strobes", n, 3);
    chk("step_ret", Ret_Cnt, 3);
`else
    // Back-to-back instructions with immediate ack
    Run = 1; PM_Ack = 1; nReset = 1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("t035_exec", Exec_En, (c % 3) == 0);
      if (c % 3 == 1) chk("t035_addr", {PM_Req, PM_Addr}, {1'b1, 8'(c / 3)});
    end
    Run = 0;
    @(negedge clk);
    chk("t035_ret", Ret_Cnt, 3);
    chk("t035_idle", PM_Req, 0);
    repeat (3) @(negedge clk);
    chk("t028_ins", Ins, 15'h5502);

    // Run dropped during a fetch still completes that instruction
    Run = 1;
    @(negedge clk);
    Run = 0;
    repeat (5) @(negedge clk);
    chk("run_drop_ret", Ret_Cnt, 4);
    chk("run_drop_idle", PM_Req, 0);
    chk("run_drop_pc", PM_Addr, 4);

    // Slow ack at PC=5
    Run = 1; n = 0;
    do begin @(negedge clk); n++; end while (!(PM_Req && PM_Addr == 8'd5) && n < 40);
    chk("t036_reach", PM_Addr, 5);
    PM_Ack = 0; n = 1;
    repeat (4) begin @(negedge clk); if (PM_Req) n++; end
    chk("t036_ins_hold", Ins, 15'h5504);
    PM_Ack = 1;
    @(negedge clk);
    chk("t036_req_cycles", n, 5);
    chk("t036_ins", Ins, 15'h5505);
    chk("t036_decode", PM_Req, 0);
    n = 0;
    repeat (3) begin @(negedge clk); if (Exec_En) n++; end
    chk("t036_one_exec", n, 1);

    // Branch to 0xFF, wrap, branch at 0x10
    Br_Take = 1; Br_Target = 8'hFF;
    next_fetch(a); chk("t037_br_ff", a, 8'hFF);
    Br_Take = 0;
    next_fetch(a); chk("t037_wrap", a, 8'h00);
    Br_Take = 1; Br_Target = 8'h10;
    next_fetch(a); chk("t037_br_10", a, 8'h10);
    Br_Target = 8'h20;
    next_fetch(a); chk("t037_br_20", a, 8'h20);
    Br_Target = 8'h07;
    next_fetch(a); chk("t038_at_07", a, 8'h07);

    // Halt with a simultaneous branch
    Halt_Ins = 1; Br_Target = 8'h30; n = 0;
    while (!Exec_En && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t038_halted", Halted, 1);
    chk("t038_req", PM_Req, 0);
    chk("t038_pc", PM_Addr, 8'h07);
    chk("t038_ret", Ret_Cnt, 12);
    Halt_Ins = 0; Br_Take = 0; n = 0;
    repeat (10) begin @(negedge clk); if (PM_Req || !Halted) n++; end
    chk("t038_stays", n, 0);

    // Reset pulse leaves HALT immediately and restarts at 0
    nReset = 0;
    #1;
    chk("t038_rst_halted", Halted, 0);
    chk("t038_rst_pc", PM_Addr, 0);
    chk("t038_rst_ret", Ret_Cnt, 0);
    @(negedge clk);
    nReset = 1;
    next_fetch(a); chk("t032_first", a, 8'h00);
    next_fetch(a); chk("t032_second", a, 8'h01);
    next_fetch(a); chk("t032_third", a, 8'h02);

    // Asynchronous reset in the middle of a fetch
    PM_Ack = 0;
    @(posedge clk);
    #2;
    chk("t039_pre_req", PM_Req, 1);
    chk("t039_pre_ret", Ret_Cnt, 2);
    nReset = 0;
    #1;
    chk("t039_req", PM_Req, 0);
    chk("t039_ret", Ret_Cnt, 0);
    chk("t039_exec", Exec_En, 0);
    @(negedge clk);
    nReset = 1; Run = 0;
`endif
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter PC_W, 8, program counter and program-memory address width.
REQ-002 SHALL have parameter INS_W, 15, instruction word width, equal to the decoder input width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port nReset  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port Run  input  1  level; 1 = sequencer may start instructions.
REQ-006 SHALL have port PM_Req  output  1  program-memory read request.
REQ-007 SHALL have port PM_Addr  output  PC_W  program-memory address, equals PC.
REQ-008 SHALL have port PM_Ack  input  1  read data valid, sampled only while PM_Req=1.
REQ-009 SHALL have port PM_Data  input  INS_W  instruction word from program memory.
REQ-010 SHALL have port Ins  output  INS_W  instruction register, drives the decoder.
REQ-011 SHALL have port Br_Take  input  1  from decoder/flags, branch taken, sampled in EXECUTE.
REQ-012 SHALL have port Br_Target  input  PC_W  branch destination, the decoder's immediate field.
REQ-013 SHALL have port Halt_Ins  input  1  from decoder, current instruction is HALT, sampled in EXECUTE.
REQ-014 SHALL have port Exec_En  output  1  one-cycle strobe gating Reg_CE, A_CE, CY_CE and DM_CE.
REQ-015 SHALL have port Halted  output  1  1 while in HALT.
REQ-016 SHALL have port Ret_Cnt  output  16  retired-instruction counter.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, HALT; encoding is free.
REQ-018 IDLE: PM_Req=0, Exec_En=0; go to FETCH when Run=1.
REQ-019 FETCH: PM_Req=1, PM_Addr=PC; on PM_Ack=1, latch PM_Data into Ins and go to DECODE; otherwise hold FETCH with PM_Req held high.
REQ-020 DECODE: one cycle, Ins stable, Exec_En=0; go to EXECUTE.
REQ-021 EXECUTE: one cycle, Exec_En=1; Ins stable.
REQ-022 EXECUTE with Halt_Ins=1: go to HALT, PC unchanged, Ret_Cnt+1; Halt_Ins overrides Br_Take.
REQ-023 EXECUTE with Br_Take=1 and Halt_Ins=0: PC <= Br_Target, Ret_Cnt+1.
REQ-024 EXECUTE otherwise: PC <= PC+1 modulo 2^PC_W (0xFF -> 0x00), Ret_Cnt+1.
REQ-025 After EXECUTE without halt: go to FETCH if Run=1, else IDLE; Run falling mid-instruction never aborts the instruction.
REQ-026 HALT: PM_Req=0, Exec_En=0, Halted=1; exit only by reset.
REQ-027 Minimum instruction latency SHALL be 3 cycles (PM_Ack in first FETCH cycle); each extra FETCH cycle adds 1.
REQ-028 PM_Ack while PM_Req=0 SHALL be ignored.
REQ-029 Ret_Cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-030 Exec_En SHALL never be high in two consecutive cycles.

Reset
REQ-031 nReset=0 SHALL immediately force IDLE, PC=0, Ins=0, Ret_Cnt=0, PM_Req=0, Exec_En=0, Halted=0, including mid-FETCH or mid-EXECUTE.
REQ-032 After nReset deasserts, first fetch SHALL be from address 0.

Configuration
REQ-033 Macro SEQ_SINGLE_STEP_EN, when defined, SHALL add port Step  input  1; IDLE goes to FETCH only on Run=1 and a Step rising edge (internal edge detect, detector register reset to 0); EXECUTE always returns to IDLE; exactly one instruction per Step edge.
REQ-034 Without SEQ_SINGLE_STEP_EN, Step SHALL be absent and behaviour SHALL be as in REQ-018 and REQ-025.

Verification
REQ-035 Reset, Run=1, PM_Ack tied 1, no branches -> PM_Addr 0,1,2 on cycles 1,4,7; Exec_En on cycles 3,6,9; Ret_Cnt=3.
REQ-036 PM_Ack delayed 4 cycles at PC=5 -> PM_Req held 5 cycles, Ins updates only on the ack cycle, one Exec_En.
REQ-037 PC=0xFF, no branch -> next PM_Addr=0x00; Br_Take=1, Br_Target=0x20 at PC=0x10 -> next PM_Addr=0x20.
REQ-038 Halt_Ins=1 and Br_Take=1 together at PC=0x07 -> Halted=1, PM_Req=0 forever, PC stays 0x07; nReset pulse -> IDLE, PC=0.
REQ-039 nReset asserted mid-FETCH with PM_Req=1 -> PM_Req=0 in the same cycle, without waiting for a clock edge; Ret_Cnt=0.
REQ-040 With SEQ_SINGLE_STEP_EN, Run=1 and 3 Step pulses -> exactly 3 Exec_En strobes, Ret_Cnt=3; Step held high produces no further instructions.
